// File: rtl/halt_monitor_pkg.sv
// Shared types and defaults for the simulation halt monitor and its console buffer.
package halt_monitor_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [31:0] DEF_TOHOST_ADDR  = 32'h0000_1000;
   localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h0000_1004;

   localparam int CON_DEPTH = 4;
   localparam int CON_WIDTH = 8;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/con_fifo.sv
// Small console byte FIFO: head entry shown on dout, zero when empty.
module con_fifo
   import halt_monitor_pkg::*;
#(
   parameter int DEPTH = CON_DEPTH,
   parameter int WIDTH = CON_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop on an empty buffer is meaningless; a push into a full one only fits if a pop frees a slot.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/halt_monitor.sv
// Watches CPU stores for tohost/console writes, drains console output, then latches a final verdict.
module halt_monitor
   import halt_monitor_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR    = DEF_TOHOST_ADDR,
   parameter logic [31:0] CONSOLE_ADDR   = DEF_CONSOLE_ADDR,
   parameter int          TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbus_we,
   input  logic [31:0] dbus_addr,
   input  logic [31:0] dbus_wdata,
   input  logic        retire,
   output logic        con_valid,
   input  logic        con_ready,
   output logic [7:0]  con_data,
   output logic        halted,
   output logic        pass,
   output logic        timeout,
   output logic [30:0] fail_code,
   output logic        con_overflow,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
);

   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        halted_q, halted_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;
   logic [30:0] fail_code_q, fail_code_d;
   logic        con_overflow_q, con_overflow_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic [31:0] instret_count_q, instret_count_d;

   logic fifo_full;
   logic fifo_empty;
   logic fifo_pop;
   logic tohost_hit;
   logic console_hit;
   logic limit_hit;

   assign tohost_hit  = dbus_we && (dbus_addr == TOHOST_ADDR) && dbus_wdata[0];
   assign console_hit = dbus_we && (dbus_addr == CONSOLE_ADDR) && (state_q == ST_RUN);
   assign limit_hit   = (cycle_count_q == TIMEOUT_LIM);
   assign fifo_pop    = con_valid && con_ready;

   con_fifo #(
      .DEPTH (CON_DEPTH),
      .WIDTH (CON_WIDTH)
   ) u_con_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (console_hit),
      .din   (dbus_wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (con_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d         = state_q;
      halted_d        = halted_q;
      pass_d          = pass_q;
      timeout_d       = timeout_q;
      fail_code_d     = fail_code_q;
      cycle_count_d   = cycle_count_q;
      instret_count_d = instret_count_q;
      // Full implies valid, so a missing ready means no slot frees up this cycle.
      con_overflow_d  = con_overflow_q || (console_hit && fifo_full && !con_ready);

      if (state_q != ST_HALTED) begin
         cycle_count_d = sat_inc(cycle_count_q);
         if (retire) begin
            instret_count_d = sat_inc(instret_count_q);
         end
      end

      case (state_q)
         ST_RUN: begin
            if (tohost_hit) begin
               state_d     = ST_DRAIN;
               pass_d      = (dbus_wdata == 32'd1);
               fail_code_d = dbus_wdata[31:1];
            end else if (limit_hit) begin
               state_d   = ST_HALTED;
               halted_d  = 1'b1;
               timeout_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (limit_hit) begin
               state_d   = ST_HALTED;
               halted_d  = 1'b1;
               timeout_d = 1'b1;
            end else if (fifo_empty) begin
               state_d  = ST_HALTED;
               halted_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_RUN;
         halted_q        <= 1'b0;
         pass_q          <= 1'b0;
         timeout_q       <= 1'b0;
         fail_code_q     <= '0;
         con_overflow_q  <= 1'b0;
         cycle_count_q   <= '0;
         instret_count_q <= '0;
      end else begin
         state_q         <= state_d;
         halted_q        <= halted_d;
         pass_q          <= pass_d;
         timeout_q       <= timeout_d;
         fail_code_q     <= fail_code_d;
         con_overflow_q  <= con_overflow_d;
         cycle_count_q   <= cycle_count_d;
         instret_count_q <= instret_count_d;
      end
   end

   assign con_valid     = !fifo_empty;
   assign halted        = halted_q;
   assign pass          = pass_q;
   assign timeout       = timeout_q;
   assign fail_code     = fail_code_q;
   assign con_overflow  = con_overflow_q;
   assign cycle_count   = cycle_count_q;
   assign instret_count = instret_count_q;

endmodule

// File: tb/tb_halt_monitor.sv
// Directed bench for halt_monitor: a default-timeout instance plus a 20-cycle-timeout instance on shared inputs.
module tb_halt_monitor;

   localparam logic [31:0] TOHOST  = 32'h0000_1000;
   localparam logic [31:0] CONSOLE = 32'h0000_1004;

   logic        clk;
   logic        rst;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic        retire;
   logic        con_ready;

   logic        a_con_valid, t_con_valid;
   logic [7:0]  a_con_data, t_con_data;
   logic        a_halted, t_halted;
   logic        a_pass, t_pass;
   logic        a_timeout, t_timeout;
   logic [30:0] a_fail_code, t_fail_code;
   logic        a_con_overflow, t_con_overflow;
   logic [31:0] a_cycle, t_cycle;
   logic [31:0] a_instret, t_instret;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] sb[$];

   halt_monitor dut_a (
      .clk           (clk),
      .rst           (rst),
      .dbus_we       (dbus_we),
      .dbus_addr     (dbus_addr),
      .dbus_wdata    (dbus_wdata),
      .retire        (retire),
      .con_valid     (a_con_valid),
      .con_ready     (con_ready),
      .con_data      (a_con_data),
      .halted        (a_halted),
      .pass          (a_pass),
      .timeout       (a_timeout),
      .fail_code     (a_fail_code),
      .con_overflow  (a_con_overflow),
      .cycle_count   (a_cycle),
      .instret_count (a_instret)
   );

   halt_monitor #(.TIMEOUT_CYCLES(20)) dut_t (
      .clk           (clk),
      .rst           (rst),
      .dbus_we       (dbus_we),
      .dbus_addr     (dbus_addr),
      .dbus_wdata    (dbus_wdata),
      .retire        (retire),
      .con_valid     (t_con_valid),
      .con_ready     (con_ready),
      .con_data      (t_con_data),
      .halted        (t_halted),
      .pass          (t_pass),
      .timeout       (t_timeout),
      .fail_code     (t_fail_code),
      .con_overflow  (t_con_overflow),
      .cycle_count   (t_cycle),
      .instret_count (t_instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      $display("store addr=%08h data=%08h", addr, data);
      dbus_we    = 1'b1;
      dbus_addr  = addr;
      dbus_wdata = data;
      step();
      dbus_we    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic drain_console(input int budget);
      int waited = 0;
      logic [7:0] exp_b;
      con_ready = 1'b1;
      while ((sb.size() != 0 || a_con_valid) && waited < budget) begin
         if (a_con_valid) begin
            if (sb.size() == 0) begin
               chk("con_unexpected_valid", {31'b0, a_con_valid}, 32'd0);
            end else begin
               exp_b = sb.pop_front();
               $display("console byte observed=%02h expected=%02h", a_con_data, exp_b);
               chk("con_data", {24'b0, a_con_data}, {24'b0, exp_b});
            end
         end
         step();
         waited++;
      end
      chk("con_drain_left", 32'(sb.size()), 32'd0);
      chk("con_drain_valid", {31'b0, a_con_valid}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      dbus_we    = 1'b0;
      dbus_addr  = '0;
      dbus_wdata = '0;
      retire     = 1'b0;
      con_ready  = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_halted", {31'b0, a_halted}, 32'd0);
      chk("rst_con_valid", {31'b0, a_con_valid}, 32'd0);
      chk("rst_con_data", {24'b0, a_con_data}, 32'd0);
      chk("rst_cycle", a_cycle, 32'd0);
      chk("rst_pass", {31'b0, a_pass}, 32'd0);
      rst = 1'b0;

      // Timeout on the 20-cycle instance with no stores; 5 retires along the way
      retire = 1'b1;
      repeat (5) step();
      retire = 1'b0;
      repeat (25) step();
      chk("to_halted", {31'b0, t_halted}, 32'd1);
      chk("to_timeout", {31'b0, t_timeout}, 32'd1);
      chk("to_pass", {31'b0, t_pass}, 32'd0);
      chk("to_cycle", t_cycle, 32'd20);
      chk("to_instret", t_instret, 32'd5);
      chk("run_cycle", a_cycle, 32'd30);
      chk("run_halted", {31'b0, a_halted}, 32'd0);

      // Tohost store in the last cycle before the limit beats the timeout
      do_reset();
      repeat (19) step();
      store(TOHOST, 32'd1);
      step();
      chk("race_halted", {31'b0, t_halted}, 32'd1);
      chk("race_timeout", {31'b0, t_timeout}, 32'd0);
      chk("race_pass", {31'b0, t_pass}, 32'd1);
      chk("race_cycle", t_cycle, 32'd21);

      // Passing store at cycle 50
      do_reset();
      repeat (49) step();
      store(TOHOST, 32'd1);
      chk("pass_drain_halted", {31'b0, a_halted}, 32'd0);
      step();
      chk("pass_halted", {31'b0, a_halted}, 32'd1);
      chk("pass_pass", {31'b0, a_pass}, 32'd1);
      chk("pass_fail_code", {1'b0, a_fail_code}, 32'd0);
      chk("pass_timeout", {31'b0, a_timeout}, 32'd0);
      chk("pass_cycle", a_cycle, 32'd51);
      retire = 1'b1;
      repeat (3) step();
      retire = 1'b0;
      chk("pass_cycle_frozen", a_cycle, 32'd51);
      chk("pass_instret_frozen", a_instret, 32'd0);
      store(TOHOST, 32'd7);
      chk("halt_store_pass", {31'b0, a_pass}, 32'd1);
      chk("halt_store_fail_code", {1'b0, a_fail_code}, 32'd0);

      // Even tohost values are ignored; 7 is a failing halt with code 3
      do_reset();
      store(TOHOST, 32'd6);
      step();
      chk("even_ignored", {31'b0, a_halted}, 32'd0);
      store(TOHOST, 32'd7);
      step();
      chk("fail_halted", {31'b0, a_halted}, 32'd1);
      chk("fail_pass", {31'b0, a_pass}, 32'd0);
      chk("fail_code", {1'b0, a_fail_code}, 32'd3);
      chk("fail_timeout", {31'b0, a_timeout}, 32'd0);

      // Five console bytes with no ready: the fifth is dropped
      do_reset();
      con_ready = 1'b0;
      chk("con_idle_valid", {31'b0, a_con_valid}, 32'd0);
      store(CONSOLE, 32'h41);
      sb.push_back(8'h41);
      chk("con_first_valid", {31'b0, a_con_valid}, 32'd1);
      chk("con_first_data", {24'b0, a_con_data}, 32'h41);
      for (int i = 1; i < 4; i++) begin
         store(CONSOLE, 32'h41 + 32'(i));
         sb.push_back(8'h41 + 8'(i));
      end
      chk("con_full_no_ovf", {31'b0, a_con_overflow}, 32'd0);
      store(CONSOLE, 32'h45);
      chk("con_overflow", {31'b0, a_con_overflow}, 32'd1);
      drain_console(20);
      chk("con_overflow_sticky", {31'b0, a_con_overflow}, 32'd1);

      // Pending console bytes hold off the halt until drained
      do_reset();
      con_ready = 1'b0;
      store(CONSOLE, 32'h78);
      sb.push_back(8'h78);
      store(CONSOLE, 32'h79);
      sb.push_back(8'h79);
      store(TOHOST, 32'd1);
      repeat (4) step();
      chk("drain_wait_halted", {31'b0, a_halted}, 32'd0);
      chk("drain_wait_valid", {31'b0, a_con_valid}, 32'd1);
      drain_console(20);
      chk("drain_empty_halted", {31'b0, a_halted}, 32'd0);
      step();
      chk("drain_done_halted", {31'b0, a_halted}, 32'd1);
      chk("drain_done_pass", {31'b0, a_pass}, 32'd1);
      chk("drain_no_ovf", {31'b0, a_con_overflow}, 32'd0);

      // Asynchronous reset while draining three queued bytes
      do_reset();
      con_ready = 1'b0;
      store(CONSOLE, 32'h31);
      store(CONSOLE, 32'h32);
      store(CONSOLE, 32'h33);
      store(TOHOST, 32'd1);
      chk("arst_pre_valid", {31'b0, a_con_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", {31'b0, a_con_valid}, 32'd0);
      chk("arst_data", {24'b0, a_con_data}, 32'd0);
      chk("arst_halted", {31'b0, a_halted}, 32'd0);
      chk("arst_cycle", a_cycle, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      store(CONSOLE, 32'h5A);
      chk("post_rst_valid", {31'b0, a_con_valid}, 32'd1);
      chk("post_rst_data", {24'b0, a_con_data}, 32'h5A);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
